// File: rtl/rssb_pkg.sv
// Shared types for the RSSB memory unit: control states and the default store-buffer entry.
package rssb_pkg;

    localparam int unsigned DefBw = 8;
    localparam int unsigned DefDw = 4;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDrain,
        StDone
    } state_e;

    typedef struct packed {
        logic [DefBw-1:0] data;
        logic [DefDw-1:0] addr;
        logic             valid;
    } fifo_entry_t;

endpackage

// File: rtl/rssb_wbuf.sv
// Circular store buffer with count-based full/empty and a youngest-match lookup used for
// forwarding buffered stores to operand reads.
module rssb_wbuf
    import rssb_pkg::*;
#(
    parameter int unsigned BW  = 8,
    parameter int unsigned DW  = 4,
    parameter int unsigned LEN = 4,
    parameter int unsigned PTR = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [BW-1:0] push_data_i,
    input  logic [DW-1:0] push_addr_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [PTR:0]  count_o,
    output logic [BW-1:0] head_data_o,
    output logic [DW-1:0] head_addr_o,
    input  logic [DW-1:0] lookup_addr_i,
    output logic          lookup_hit_o,
    output logic [BW-1:0] lookup_data_o
);

    typedef struct packed {
        logic [BW-1:0] data;
        logic [DW-1:0] addr;
        logic          valid;
    } entry_t;

    localparam logic [PTR:0] Depth = (PTR+1)'(LEN);

    entry_t         buf_q [LEN];
    entry_t         buf_d [LEN];
    logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR:0]   count_q, count_d;
    logic           do_push, do_pop;
    logic [PTR-1:0] scan_idx;

    function automatic logic [PTR-1:0] ptr_inc(input logic [PTR-1:0] p);
        return (p == PTR'(LEN - 1)) ? '0 : p + PTR'(1);
    endfunction

    assign full_o      = (count_q == Depth);
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_data_o = buf_q[rd_ptr_q].data;
    assign head_addr_o = buf_q[rd_ptr_q].addr;

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            buf_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            buf_d[wr_ptr_q] = '{data: push_data_i, addr: push_addr_i, valid: 1'b1};
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR+1)'(1);
            2'b01:   count_d = count_q - (PTR+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        lookup_hit_o  = 1'b0;
        lookup_data_o = '0;
        scan_idx      = '0;
        for (int unsigned k = 0; k < LEN; k++) begin
            scan_idx = PTR'((32'(rd_ptr_q) + k) % LEN);
            if (buf_q[scan_idx].valid && (buf_q[scan_idx].addr == lookup_addr_i)) begin
                lookup_hit_o  = 1'b1;
                lookup_data_o = buf_q[scan_idx].data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LEN; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rssb_mem_unit.sv
// RSSB memory unit: instruction ROM, data memory, accumulator and a forwarding store buffer
// that issues operands to an external ALU and retires results in the background.
module rssb_mem_unit
    import rssb_pkg::*;
#(
    parameter int unsigned BW        = 8,
    parameter int unsigned IW        = 4,
    parameter int unsigned IM        = 16,
    parameter int unsigned DW        = 4,
    parameter int unsigned DM        = 16,
    parameter int unsigned LEN       = 4,
    parameter int unsigned PTR       = 2,
    parameter int unsigned HALT_ADDR = DM - 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [IW-1:0]        prog_addr,
    input  logic [DW-1:0]        prog_data,
    input  logic                 dinit_we,
    input  logic [DW-1:0]        dinit_addr,
    input  logic [BW-1:0]        dinit_data,
    input  logic                 start,
    input  logic                 drain_stall,
    input  logic                 result_valid,
    input  logic [BW-1:0]        result,
    input  logic                 flag,
    output logic                 ena,
    output logic [1:0][BW-1:0]   data,
    output logic                 busy,
    output logic                 done,
    output logic [IW-1:0]        pc_out
);

    localparam logic [DW-1:0] HaltAddr = DW'(HALT_ADDR);

    logic [DW-1:0] imem [IM];
    logic [BW-1:0] dmem [DM];

    state_e        state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [BW-1:0] acc_q, acc_d;
    logic          ena_q, ena_d;
    logic [BW-1:0] opnd_q, opnd_d;
    logic [BW-1:0] opacc_q, opacc_d;
    logic [DW-1:0] addr_q, addr_d;

    logic          idle_like;
    logic [DW-1:0] cur_addr;
    logic [BW-1:0] operand;
    logic          fwd_hit;
    logic [BW-1:0] fwd_data;
    logic          wb_push, wb_pop;
    logic          wb_full, wb_empty;
    logic [PTR:0]  wb_count;
    logic [BW-1:0] wb_head_data;
    logic [DW-1:0] wb_head_addr;

    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign cur_addr  = imem[pc_q];
    assign operand   = fwd_hit ? fwd_data : dmem[cur_addr];
    assign wb_pop    = !wb_empty && !drain_stall;

    rssb_wbuf #(
        .BW (BW),
        .DW (DW),
        .LEN(LEN),
        .PTR(PTR)
    ) u_wbuf (
        .clk          (clk),
        .rst_n        (rst),
        .push_i       (wb_push),
        .push_data_i  (result),
        .push_addr_i  (addr_q),
        .pop_i        (wb_pop),
        .full_o       (wb_full),
        .empty_o      (wb_empty),
        .count_o      (wb_count),
        .head_data_o  (wb_head_data),
        .head_addr_o  (wb_head_addr),
        .lookup_addr_i(cur_addr),
        .lookup_hit_o (fwd_hit),
        .lookup_data_o(fwd_data)
    );

    // Buffer is always empty in IDLE/DONE, so retire and init writes never collide.
    always_ff @(posedge clk) begin
        if (prog_we && idle_like) begin
            imem[prog_addr] <= prog_data;
        end
        if (wb_pop) begin
            dmem[wb_head_addr] <= wb_head_data;
        end else if (dinit_we && idle_like) begin
            dmem[dinit_addr] <= dinit_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ena_d   = ena_q;
        opnd_d  = opnd_q;
        opacc_d = opacc_q;
        addr_d  = addr_q;
        wb_push = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    pc_d    = '0;
                    acc_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (cur_addr == HaltAddr) begin
                    state_d = StDrain;
                end else if (!wb_full) begin
                    opnd_d  = operand;
                    opacc_d = acc_q;
                    addr_d  = cur_addr;
                    ena_d   = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (result_valid) begin
                    acc_d   = result;
                    wb_push = 1'b1;
                    pc_d    = pc_q + (flag ? IW'(2) : IW'(1));
                    ena_d   = 1'b0;
                    state_d = StIssue;
                end
            end
            StDrain: begin
                if (wb_count == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            acc_q   <= '0;
            ena_q   <= 1'b0;
            opnd_q  <= '0;
            opacc_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            ena_q   <= ena_d;
            opnd_q  <= opnd_d;
            opacc_q <= opacc_d;
            addr_q  <= addr_d;
        end
    end

    assign ena     = ena_q;
    assign data[0] = opnd_q;
    assign data[1] = opacc_q;
    assign busy    = (state_q == StIssue) || (state_q == StWait) || (state_q == StDrain);
    assign done    = (state_q == StDone);
    assign pc_out  = pc_q;

endmodule

// File: tb/tb_rssb_mem_unit.sv
// Bench for rssb_mem_unit: table vectors, hand sequences for stall/full/wrap/reset corners,
// and random programs checked against an architectural (unbuffered) execution model.
module tb_rssb_mem_unit;

    localparam int unsigned BW   = 8;
    localparam int unsigned IW   = 4;
    localparam int unsigned IM   = 16;
    localparam int unsigned DW   = 4;
    localparam int unsigned DM   = 16;
    localparam int unsigned LEN  = 4;
    localparam int unsigned PTR  = 2;
    localparam int unsigned HALT = DM - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                prog_we = 1'b0;
    logic [IW-1:0]       prog_addr = '0;
    logic [DW-1:0]       prog_data = '0;
    logic                dinit_we = 1'b0;
    logic [DW-1:0]       dinit_addr = '0;
    logic [BW-1:0]       dinit_data = '0;
    logic                start = 1'b0;
    logic                drain_stall = 1'b0;
    logic                result_valid = 1'b0;
    logic [BW-1:0]       result = '0;
    logic                flag = 1'b0;
    logic                ena;
    logic [1:0][BW-1:0]  data;
    logic                busy;
    logic                done;
    logic [IW-1:0]       pc_out;

    always #5 clk = ~clk;

    rssb_mem_unit #(
        .BW(BW), .IW(IW), .IM(IM), .DW(DW), .DM(DM), .LEN(LEN), .PTR(PTR), .HALT_ADDR(HALT)
    ) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .dinit_we(dinit_we), .dinit_addr(dinit_addr), .dinit_data(dinit_data),
        .start(start), .drain_stall(drain_stall), .result_valid(result_valid),
        .result(result), .flag(flag), .ena(ena), .data(data), .busy(busy), .done(done),
        .pc_out(pc_out)
    );

    typedef struct {
        int a0; int a1; int v0; int v1; int e_d0; int e_d1; int e_fin;
    } vec_t;

    vec_t          tbl [5];
    int            n_vec = 0;
    int            n_err = 0;
    bit            rand_stall = 1'b0;
    bit            rand_lat = 1'b0;
    logic [7:0]    d0, d1, v, r, acc_m;
    logic [3:0]    p, pc_m;
    logic [7:0]    dm_m [DM];
    logic [3:0]    im_m [IM];
    bit            ok, fl;
    int            a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (rand_stall) drain_stall = 1'($urandom_range(0, 1));
    endtask

    task automatic prog_w(input int ad, input int dd);
        prog_we = 1'b1; prog_addr = 4'(ad); prog_data = 4'(dd);
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic dinit_w(input int ad, input int dd);
        dinit_we = 1'b1; dinit_addr = 4'(ad); dinit_data = 8'(dd);
        @(negedge clk);
        dinit_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ena(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ena === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL ena_timeout: got ena=0, want ena=1 within 100 cycles");
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            cyc();
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: got done=0, want done=1 within 100 cycles");
        end
    endtask

    // fmode: 0 no skip, 1 force skip, 2 skip on borrow
    task automatic do_op(input int fmode, input bit pop_now,
                         output logic [7:0] o0, output logic [7:0] o1, output logic [3:0] opc);
        bit got;
        wait_ena(got);
        o0 = data[0]; o1 = data[1]; opc = pc_out;
        if (!got) return;
        if (rand_lat) begin
            repeat ($urandom_range(0, 2)) cyc();
            check("hold_d0", 32'(data[0]), 32'(o0));
        end
        result_valid = 1'b1;
        result = o0 - o1;
        flag = (fmode == 2) ? (o0 < o1) : (fmode == 1);
        if (pop_now) drain_stall = 1'b0;
        @(negedge clk);
        result_valid = 1'b0;
        flag = 1'b0;
        if (pop_now) drain_stall = 1'b1;
    endtask

    // Non-destructive dmem read: one op at acc=0 writes the operand back unchanged.
    task automatic readback(input int ad, output logic [7:0] val);
        bit sv_st, sv_lt, got;
        logic [7:0] t1;
        logic [3:0] tp;
        sv_st = rand_stall; sv_lt = rand_lat;
        rand_stall = 1'b0; rand_lat = 1'b0; drain_stall = 1'b0;
        prog_w(0, ad);
        prog_w(1, HALT);
        start_run();
        do_op(0, 1'b0, val, t1, tp);
        wait_done(got);
        rand_stall = sv_st; rand_lat = sv_lt;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3, 3,   5,  9,   5,   5,   0};
        tbl[1] = '{1, 2,  10, 30,  30,  10,  20};
        tbl[2] = '{4, 5,  50, 20,  20,  50, 226};
        tbl[3] = '{7, 7, 200,  1, 200, 200,   0};
        tbl[4] = '{0, 14, 255, 0,   0, 255,   1};

        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ena", 32'(ena), 0);
            check("rst_d0", 32'(data[0]), 0);
            check("rst_d1", 32'(data[1]), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_pc", 32'(pc_out), 0);
        end
        rst = 1'b1;
        @(negedge clk);

        // Two-op programs with stores held in the buffer, then drained.
        foreach (tbl[i]) begin
            dinit_w(tbl[i].a0, tbl[i].v0);
            if (tbl[i].a1 != tbl[i].a0) dinit_w(tbl[i].a1, tbl[i].v1);
            prog_w(0, tbl[i].a0); prog_w(1, tbl[i].a1); prog_w(2, HALT); prog_w(3, HALT);
            drain_stall = 1'b1;
            start_run();
            do_op(2, 1'b0, d0, d1, p);
            check("t_op1_d0", 32'(d0), tbl[i].v0);
            check("t_op1_d1", 32'(d1), 0);
            do_op(2, 1'b0, d0, d1, p);
            check("t_op2_d0", 32'(d0), tbl[i].e_d0);
            check("t_op2_d1", 32'(d1), tbl[i].e_d1);
            repeat (3) cyc();
            check("t_drain_done", 32'(done), 0);
            check("t_drain_busy", 32'(busy), 1);
            drain_stall = 1'b0;
            wait_done(ok);
            check("t_done", 32'(done), 1);
            readback(tbl[i].a1, v);
            check("t_final", 32'(v), tbl[i].e_fin);
        end

        // Skip at pc=0 lands on imem[2].
        drain_stall = 1'b0;
        dinit_w(6, 40); dinit_w(8, 77);
        prog_w(0, 6); prog_w(1, 7); prog_w(2, 8); prog_w(3, HALT);
        start_run();
        do_op(1, 1'b0, d0, d1, p);
        check("s_op1_d0", 32'(d0), 40);
        wait_ena(ok);
        check("s_pc", 32'(pc_out), 2);
        check("s_d0", 32'(data[0]), 77);
        check("s_d1", 32'(data[1]), 40);
        do_op(0, 1'b0, d0, d1, p);
        wait_done(ok);

        // Full buffer holds issue until one entry retires.
        prog_w(0, 1); prog_w(1, 2); prog_w(2, 3); prog_w(3, 4); prog_w(4, 5); prog_w(5, HALT);
        drain_stall = 1'b1;
        start_run();
        repeat (4) do_op(0, 1'b0, d0, d1, p);
        repeat (3) cyc();
        check("f_hold_ena", 32'(ena), 0);
        check("f_hold_pc", 32'(pc_out), 4);
        check("f_hold_busy", 32'(busy), 1);
        drain_stall = 1'b0;
        @(negedge clk);
        drain_stall = 1'b1;
        check("f_pop_ena", 32'(ena), 0);
        @(negedge clk);
        check("f_issue_ena", 32'(ena), 1);
        do_op(0, 1'b0, d0, d1, p);
        drain_stall = 1'b0;
        wait_done(ok);

        // Push and pop together keep the count at 3: next issue goes, the one after is full.
        prog_w(5, 6); prog_w(6, HALT);
        drain_stall = 1'b1;
        start_run();
        repeat (3) do_op(0, 1'b0, d0, d1, p);
        do_op(0, 1'b1, d0, d1, p);
        cyc();
        check("pp_issue_ena", 32'(ena), 1);
        do_op(0, 1'b0, d0, d1, p);
        repeat (2) cyc();
        check("pp_full_ena", 32'(ena), 0);
        drain_stall = 1'b0;
        do_op(0, 1'b0, d0, d1, p);
        wait_done(ok);

        // pc wrap: 15 with skip -> 1, 15 without skip -> 0.
        for (int i = 0; i < 16; i++) prog_w(i, 2);
        start_run();
        do_op(0, 1'b0, d0, d1, p);
        check("w_pc0", 32'(p), 0);
        for (int k = 0; k < 8; k++) begin
            do_op(1, 1'b0, d0, d1, p);
            check("w_pc_skip", 32'(p), 32'(1 + 2 * k));
        end
        wait_ena(ok);
        check("w_wrap_skip", 32'(pc_out), 1);
        for (int k = 0; k < 7; k++) do_op(1, 1'b0, d0, d1, p);
        do_op(0, 1'b0, d0, d1, p);
        check("w_pc15", 32'(p), 15);
        wait_ena(ok);
        check("w_wrap_noskip", 32'(pc_out), 0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT discards the two buffered stores.
        dinit_w(1, 11); dinit_w(2, 22);
        prog_w(0, 1); prog_w(1, 1); prog_w(2, 2); prog_w(3, HALT);
        drain_stall = 1'b1;
        start_run();
        repeat (2) do_op(0, 1'b0, d0, d1, p);
        wait_ena(ok);
        rst = 1'b0;
        #1;
        check("mr_ena", 32'(ena), 0);
        check("mr_d0", 32'(data[0]), 0);
        check("mr_d1", 32'(data[1]), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_pc", 32'(pc_out), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        readback(1, v);
        check("mr_mem1", 32'(v), 11);
        readback(2, v);
        check("mr_mem2", 32'(v), 22);

        // Random programs; halt at 14/15 guarantees termination since pc steps by 1 or 2.
        for (int it = 0; it < 12; it++) begin
            rand_stall = 1'b0; rand_lat = 1'b0; drain_stall = 1'b0;
            for (int i = 0; i < 16; i++) begin
                dm_m[i] = 8'($urandom);
                dinit_w(i, int'(dm_m[i]));
            end
            for (int i = 0; i < 14; i++) im_m[i] = 4'($urandom_range(0, 14));
            im_m[14] = 4'(HALT); im_m[15] = 4'(HALT);
            for (int i = 0; i < 16; i++) prog_w(i, int'(im_m[i]));
            rand_stall = 1'b1; rand_lat = 1'b1;
            start_run();
            pc_m = '0; acc_m = '0;
            for (int s = 0; s < 20; s++) begin
                a = int'(im_m[pc_m]);
                if (a == HALT) break;
                do_op(2, 1'b0, d0, d1, p);
                check("r_pc", 32'(p), 32'(pc_m));
                check("r_d0", 32'(d0), 32'(dm_m[a]));
                check("r_d1", 32'(d1), 32'(acc_m));
                r = dm_m[a] - acc_m;
                fl = (dm_m[a] < acc_m);
                acc_m = r;
                dm_m[a] = r;
                pc_m = pc_m + 4'(fl ? 2 : 1);
            end
            wait_done(ok);
            check("r_done", 32'(done), 1);
            for (int i = 0; i < 15; i++) begin
                readback(i, v);
                check("r_mem", 32'(v), 32'(dm_m[i]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
